hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 123 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit for the in-order pipeline. Tracks the destination registers of
// in-flight writers through DEPTH post-ID slots (slot 0 = EX ... slot DEPTH-1 = WB).
module hazard_scoreboard #(
  parameter  int REG_IDX_W  = 5,
  parameter  int DEPTH      = 3,
  parameter  int FWD_EN     = 1,
  parameter  int LOAD_AVAIL = 1,
  parameter  int CNT_W      = 32,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 id_valid_i,
  input  logic [REG_IDX_W-1:0] id_rs1_idx_i,
  input  logic [REG_IDX_W-1:0] id_rs2_idx_i,
  input  logic                 id_rs1_used_i,
  input  logic                 id_rs2_used_i,
  input  logic [REG_IDX_W-1:0] id_rd_idx_i,
  input  logic                 id_reg_wr_i,
  input  logic                 id_rd_mem_i,
  input  logic                 flush_i,
  input  logic                 stall_ext_i,
  input  logic                 cnt_clr_i,
  output logic                 stall_o,
  output logic                 issue_o,
  output logic [SEL_W-1:0]     fwd_a_sel_o,
  output logic [SEL_W-1:0]     fwd_b_sel_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  logic [DEPTH-1:0]     slot_vld_q, slot_wr_q, slot_ld_q;
  logic [DEPTH-1:0]     slot_vld_d, slot_wr_d, slot_ld_d;
  logic [REG_IDX_W-1:0] slot_rd_q [DEPTH];
  logic [REG_IDX_W-1:0] slot_rd_d [DEPTH];
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0] match_a, match_b;
  logic             ld_a, ld_b;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             hazard, issue;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match_a[gi] = id_rs1_used_i & (id_rs1_idx_i != '0) & slot_vld_q[gi] &
                         slot_wr_q[gi] & (slot_rd_q[gi] == id_rs1_idx_i);
    assign match_b[gi] = id_rs2_used_i & (id_rs2_idx_i != '0) & slot_vld_q[gi] &
                         slot_wr_q[gi] & (slot_rd_q[gi] == id_rs2_idx_i);
  end

  // Scan oldest to youngest so the youngest matching slot wins.
  always_comb begin
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    sel_a = '0;
    sel_b = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_a[i]) begin
        sel_a = SEL_W'(i + 1);
        ld_a  = slot_ld_q[i] && (i < LOAD_AVAIL);
      end
      if (match_b[i]) begin
        sel_b = SEL_W'(i + 1);
        ld_b  = slot_ld_q[i] && (i < LOAD_AVAIL);
      end
    end
  end

  if (FWD_EN != 0) begin : g_fwd
    assign hazard      = id_valid_i & (ld_a | ld_b);
    assign fwd_a_sel_o = (rst_n_i && !ld_a) ? sel_a : '0;
    assign fwd_b_sel_o = (rst_n_i && !ld_b) ? sel_b : '0;
  end else begin : g_nofwd
    assign hazard      = id_valid_i & ((|match_a) | (|match_b));
    assign fwd_a_sel_o = '0;
    assign fwd_b_sel_o = '0;
  end

  assign issue       = rst_n_i & id_valid_i & ~hazard & ~flush_i & ~stall_ext_i;
  assign issue_o     = issue;
  assign stall_o     = rst_n_i & hazard;
  assign stall_cnt_o = stall_cnt_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_next
    if (gi == 0) begin : g_head
      assign slot_vld_d[gi] = issue;
      assign slot_rd_d[gi]  = issue ? id_rd_idx_i : '0;
      assign slot_wr_d[gi]  = issue & id_reg_wr_i & (id_rd_idx_i != '0);
      assign slot_ld_d[gi]  = issue & id_rd_mem_i;
    end else begin : g_shift
      assign slot_vld_d[gi] = slot_vld_q[gi-1];
      assign slot_rd_d[gi]  = slot_rd_q[gi-1];
      assign slot_wr_d[gi]  = slot_wr_q[gi-1];
      assign slot_ld_d[gi]  = slot_ld_q[gi-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr_i)
      stall_cnt_d = '0;
    else if (hazard && !flush_i && !stall_ext_i && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      slot_vld_q  <= '0;
      slot_wr_q   <= '0;
      slot_ld_q   <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) slot_rd_q[i] <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      // A memory-wait freeze holds the whole tracker in place.
      if (!stall_ext_i) begin
        slot_vld_q <= slot_vld_d;
        slot_wr_q  <= slot_wr_d;
        slot_ld_q  <= slot_ld_d;
        for (int i = 0; i < DEPTH; i++) slot_rd_q[i] <= slot_rd_d[i];
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench: instance 0 forwards (defaults), instance 1 is stall-until-retired
// with a 2-bit counter so saturation is reachable.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, rs1_used, rs2_used, reg_wr, rd_mem, flush, stall_ext, cnt_clr;
  logic [4:0] rs1_idx, rs2_idx, rd_idx;

  logic        stall0, issue0, stall1, issue1;
  logic [1:0]  a0, b0, a1, b1;
  logic [31:0] cnt0;
  logic [1:0]  cnt1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_fwd (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid),
    .id_rs1_idx_i(rs1_idx), .id_rs2_idx_i(rs2_idx),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .id_rd_idx_i(rd_idx), .id_reg_wr_i(reg_wr), .id_rd_mem_i(rd_mem),
    .flush_i(flush), .stall_ext_i(stall_ext), .cnt_clr_i(cnt_clr),
    .stall_o(stall0), .issue_o(issue0), .fwd_a_sel_o(a0), .fwd_b_sel_o(b0),
    .stall_cnt_o(cnt0)
  );

  hazard_scoreboard #(.FWD_EN(0), .CNT_W(2)) u_nofwd (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid),
    .id_rs1_idx_i(rs1_idx), .id_rs2_idx_i(rs2_idx),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .id_rd_idx_i(rd_idx), .id_reg_wr_i(reg_wr), .id_rd_mem_i(rd_mem),
    .flush_i(flush), .stall_ext_i(stall_ext), .cnt_clr_i(cnt_clr),
    .stall_o(stall1), .issue_o(issue1), .fwd_a_sel_o(a1), .fwd_b_sel_o(b1),
    .stall_cnt_o(cnt1)
  );

  typedef struct {
    int          dut;
    logic        rst_n, val;
    logic [4:0]  r1;
    logic        u1;
    logic [4:0]  r2;
    logic        u2;
    logic [4:0]  rd;
    logic        wr, ld, fl, sx, clr;
    logic        e_stall, e_issue;
    logic [1:0]  e_a, e_b;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int d, rs, v, r1, u1, r2, u2, rd, wr, ld, fl, sx, clr,
                              est, eis, ea, eb, ecnt);
    vec_t t;
    t.dut = d;  t.rst_n = rs[0]; t.val = v[0];
    t.r1 = r1[4:0]; t.u1 = u1[0]; t.r2 = r2[4:0]; t.u2 = u2[0];
    t.rd = rd[4:0]; t.wr = wr[0]; t.ld = ld[0];
    t.fl = fl[0]; t.sx = sx[0]; t.clr = clr[0];
    t.e_stall = est[0]; t.e_issue = eis[0]; t.e_a = ea[1:0]; t.e_b = eb[1:0];
    t.e_cnt = ecnt;
    return t;
  endfunction

  task automatic chk(input int row, input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL row%0d %s: got %0d expected %0d", row, nm, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; rs1_idx = '0; rs2_idx = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    rd_idx = '0; reg_wr = 1'b0; rd_mem = 1'b0; flush = 1'b0; stall_ext = 1'b0; cnt_clr = 1'b0;

    //           d rs v r1 u1 r2 u2 rd wr ld fl sx clr  st is a b cnt
    // reset, then empty tracker
    vecs.push_back(mk(0,0,1, 1,1, 2,1, 3,1,0, 0,0,0,  0,0,0,0,0));
    vecs.push_back(mk(0,0,1, 1,1, 2,1, 3,1,0, 0,0,0,  0,0,0,0,0));
    vecs.push_back(mk(0,1,1, 1,1, 2,1, 3,1,0, 0,0,0,  0,1,0,0,0));
    // ALU forwarding from slots 0,1,2 then falling off
    vecs.push_back(mk(0,1,1, 1,1, 0,0, 5,1,0, 0,0,0,  0,1,0,0,0));
    vecs.push_back(mk(0,1,1, 5,1, 0,0, 0,0,0, 0,0,0,  0,1,1,0,0));
    vecs.push_back(mk(0,1,1, 5,1, 3,1, 0,0,0, 0,0,0,  0,1,2,3,0));
    vecs.push_back(mk(0,1,1, 5,1, 3,1, 0,0,0, 0,0,0,  0,1,3,0,0));
    vecs.push_back(mk(0,1,1, 5,1, 0,0, 0,0,0, 0,0,0,  0,1,0,0,0));
    // load-use
    vecs.push_back(mk(0,1,1, 1,1, 0,0, 7,1,1, 0,0,0,  0,1,0,0,0));
    vecs.push_back(mk(0,1,1, 0,0, 7,1, 0,0,0, 0,0,0,  1,0,0,0,0));
    vecs.push_back(mk(0,1,1, 0,0, 7,1, 0,0,0, 0,0,0,  0,1,0,2,1));
    vecs.push_back(mk(0,1,1, 0,0, 7,1, 0,0,0, 0,0,0,  0,1,0,3,1));
    // youngest-match priority, x0 writer/reader
    vecs.push_back(mk(0,1,1, 0,0, 0,0, 6,1,0, 0,0,0,  0,1,0,0,1));
    vecs.push_back(mk(0,1,1, 0,0, 0,0, 6,1,0, 0,0,0,  0,1,0,0,1));
    vecs.push_back(mk(0,1,1, 6,1, 0,0, 0,0,0, 0,0,0,  0,1,1,0,1));
    vecs.push_back(mk(0,1,1, 0,0, 0,0, 0,1,0, 0,0,0,  0,1,0,0,1));
    vecs.push_back(mk(0,1,1, 0,1, 6,1, 0,0,0, 0,0,0,  0,1,0,3,1));
    // freeze with a load in slot 0
    vecs.push_back(mk(0,1,1, 1,1, 0,0, 7,1,1, 0,0,0,  0,1,0,0,1));
    vecs.push_back(mk(0,1,1, 0,0, 7,1, 0,0,0, 0,1,0,  1,0,0,0,1));
    vecs.push_back(mk(0,1,1, 0,0, 7,1, 0,0,0, 0,1,0,  1,0,0,0,1));
    vecs.push_back(mk(0,1,1, 0,0, 7,1, 0,0,0, 0,0,0,  1,0,0,0,1));
    vecs.push_back(mk(0,1,1, 0,0, 7,1, 0,0,0, 0,0,0,  0,1,0,2,2));
    // flush during load-use
    vecs.push_back(mk(0,1,1, 1,1, 0,0, 9,1,1, 0,0,0,  0,1,0,0,2));
    vecs.push_back(mk(0,1,1, 9,1, 0,0, 0,0,0, 1,0,0,  1,0,0,0,2));
    vecs.push_back(mk(0,1,1, 9,1, 0,0, 0,0,0, 0,0,0,  0,1,2,0,2));
    // counter clear
    vecs.push_back(mk(0,1,0, 0,0, 0,0, 0,0,0, 0,0,1,  0,0,0,0,2));
    vecs.push_back(mk(0,1,0, 0,0, 0,0, 0,0,0, 0,0,0,  0,0,0,0,0));
    // mid-stream reset
    vecs.push_back(mk(0,1,1, 1,1, 0,0, 7,1,1, 0,0,0,  0,1,0,0,0));
    vecs.push_back(mk(0,1,1, 0,0, 7,1, 0,0,0, 0,0,0,  1,0,0,0,0));
    vecs.push_back(mk(0,1,1, 0,0, 7,1, 0,0,0, 0,1,0,  0,0,0,2,1));
    vecs.push_back(mk(0,0,1, 0,0, 7,1, 0,0,0, 0,0,0,  0,0,0,0,0));
    vecs.push_back(mk(0,1,1, 0,0, 7,1, 0,0,0, 0,0,0,  0,1,0,0,0));
    // no-forward instance: stall through EX/MEM/WB, then saturation
    vecs.push_back(mk(1,0,1, 1,1, 0,0, 4,1,0, 0,0,0,  0,0,0,0,0));
    vecs.push_back(mk(1,1,1, 1,1, 0,0, 4,1,0, 0,0,0,  0,1,0,0,0));
    vecs.push_back(mk(1,1,1, 4,1, 0,0, 0,0,0, 0,0,0,  1,0,0,0,0));
    vecs.push_back(mk(1,1,1, 4,1, 0,0, 0,0,0, 0,0,0,  1,0,0,0,1));
    vecs.push_back(mk(1,1,1, 4,1, 0,0, 0,0,0, 0,0,0,  1,0,0,0,2));
    vecs.push_back(mk(1,1,1, 4,1, 0,0, 0,0,0, 0,0,0,  0,1,0,0,3));
    vecs.push_back(mk(1,1,1, 0,0, 0,0, 4,1,0, 0,0,0,  0,1,0,0,3));
    vecs.push_back(mk(1,1,1, 4,1, 0,0, 0,0,0, 0,0,0,  1,0,0,0,3));
    vecs.push_back(mk(1,1,1, 4,1, 0,0, 0,0,0, 0,0,0,  1,0,0,0,3));

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; id_valid = vecs[i].val;
      rs1_idx = vecs[i].r1; rs1_used = vecs[i].u1;
      rs2_idx = vecs[i].r2; rs2_used = vecs[i].u2;
      rd_idx = vecs[i].rd; reg_wr = vecs[i].wr; rd_mem = vecs[i].ld;
      flush = vecs[i].fl; stall_ext = vecs[i].sx; cnt_clr = vecs[i].clr;
      @(negedge clk);
      if (vecs[i].dut == 0) begin
        chk(i, "stall", {31'd0, stall0}, {31'd0, vecs[i].e_stall});
        chk(i, "issue", {31'd0, issue0}, {31'd0, vecs[i].e_issue});
        chk(i, "fwd_a", {30'd0, a0}, {30'd0, vecs[i].e_a});
        chk(i, "fwd_b", {30'd0, b0}, {30'd0, vecs[i].e_b});
        chk(i, "cnt",   cnt0, vecs[i].e_cnt);
      end else begin
        chk(i, "nf_stall", {31'd0, stall1}, {31'd0, vecs[i].e_stall});
        chk(i, "nf_issue", {31'd0, issue1}, {31'd0, vecs[i].e_issue});
        chk(i, "nf_fwd_a", {30'd0, a1}, {30'd0, vecs[i].e_a});
        chk(i, "nf_fwd_b", {30'd0, b1}, {30'd0, vecs[i].e_b});
        chk(i, "nf_cnt",   {30'd0, cnt1}, vecs[i].e_cnt);
      end
      $display("row%0d dut%0d v=%0d rs1=%0d rs2=%0d rd=%0d stall=%0d/%0d issue=%0d/%0d a=%0d/%0d b=%0d/%0d cnt=%0d/%0d",
               i, vecs[i].dut, vecs[i].val, vecs[i].r1, vecs[i].r2, vecs[i].rd,
               stall0, stall1, issue0, issue1, a0, a1, b0, b1, cnt0, cnt1);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
